ddram_cache_ctrl: RTL and testbench
===================================

Name: ddram_cache_ctrl

Overview:
- Sequencer between the 8-bit MultiComp CPU bus and the MiSTer DDRAM Avalon port.
- Drives the small associative word cache: looks up every access, fills it on read misses, and updates it on write hits.
- 64-bit DDRAM words are the cache line; the CPU sees bytes selected by cpu_addr[2:0].
- Writes are write-through; write misses do not allocate.

Parameters:
- CPU_ADDR_WIDTH, 16, CPU byte address width; cache key width is CPU_ADDR_WIDTH-3.
- DDRAM_BASE, 29'h0600000, DDRAM word address of CPU byte 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  access request, level; held with cpu_we/addr/wdata until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  CPU_ADDR_WIDTH  byte address
- cpu_wdata  in  8  write byte
- cpu_rdata  out  8  read byte, valid in the cpu_ack cycle and held until next ack
- cpu_ack  out  1  one-cycle completion pulse
- cache_addr  out  CPU_ADDR_WIDTH-3  cache key (word index)
- cache_wdata  out  64  line written to cache
- cache_rdata  in  64  cache line for cache_addr (combinational)
- cache_hit  in  1  cache data_valid for cache_addr (combinational)
- cache_wr_enable  out  1  cache write strobe; cache commits on its falling edge
- ddram_addr  out  29  DDRAM word address = DDRAM_BASE + word index
- ddram_burstcnt  out  8  constant 1
- ddram_rd  out  1  read request
- ddram_we  out  1  write request
- ddram_din  out  64  write data: cpu_wdata replicated to all 8 lanes
- ddram_be  out  8  byte enable = 1 << lane
- ddram_dout  in  64  read data
- ddram_dout_ready  in  1  read data valid
- ddram_busy  in  1  waitrequest

Behaviour:
- Reset values (reset_n low, async): state IDLE; cpu_ack, cache_wr_enable, ddram_rd, ddram_we = 0; cpu_rdata = 0; cache_addr, cache_wdata = 0.
- Request latch: in IDLE, cpu_req=1 latches addr, we, wdata and lane = cpu_addr[2:0]. cache_addr is driven from the latched word index and stays stable until IDLE is re-entered.
- States: IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, FILL, COMMIT, ACK.
- IDLE: on cpu_req, latch the request and go to LOOKUP. Otherwise remain.
- LOOKUP: register hit = cache_hit and line = cache_rdata.
  - Read hit: cpu_rdata = line byte[lane]; go to ACK. Request to ack is 2 cycles.
  - Read miss: go to RD_REQ.
  - Write (hit or miss): go to WR_REQ.
- RD_REQ: ddram_rd = 1. Hold ddram_rd and ddram_addr while ddram_busy = 1. Go to RD_WAIT on the first cycle with ddram_busy = 0.
- RD_WAIT: wait for ddram_dout_ready. On it, capture ddram_dout into cache_wdata, set cpu_rdata = ddram_dout byte[lane], and go to FILL. No timeout.
- WR_REQ: ddram_we = 1 with ddram_be and ddram_din. Hold while ddram_busy.
  - When accepted on a hit: cache_wdata = line with byte[lane] replaced by wdata; go to FILL.
  - When accepted on a miss: go to ACK.
- FILL: cache_wr_enable = 1 for exactly one cycle; go to COMMIT.
- COMMIT: cache_wr_enable = 0; cache_addr and cache_wdata held, because the cache commits this cycle. Go to ACK.
- ACK: cpu_ack = 1 for one cycle; return to IDLE.
  - The requester drops or changes cpu_req after ack.
  - IDLE accepts a new request on the cycle after ACK; back-to-back requests are allowed.
- ddram_rd and ddram_we are never both high. Both are only asserted in RD_REQ and WR_REQ respectively.
- ddram_dout_ready outside RD_WAIT is ignored. This covers stale data returned after a reset_n during RD_WAIT.
- reset_n low mid-operation aborts immediately: strobes drop and no cpu_ack is issued.
  - A reset between FILL and COMMIT leaves the cache unchanged; its falling-edge commit is suppressed by its own reset.
- Address arithmetic: ddram_addr = DDRAM_BASE + {16'b0, word index} modulo 2^29.

Test Plan:
- Read miss then hit: cpu read 0x1234, cache_hit = 0, DDRAM returns 64'h8877665544332211 after 5 cycles.
  - ddram_addr = 0x0600246, one ddram_rd pulse, cpu_rdata = 0x55, cache filled with that line.
  - A repeat read of 0x1234 has cache_hit = 1 and gives cpu_ack 2 cycles after cpu_req, with no ddram_rd.
- Write hit: write 0xAA to 0x1233 while cached line = 64'h8877665544332211.
  - ddram_be = 8'h08, ddram_din = 64'hAAAA_AAAA_AAAA_AAAA.
  - cache_wdata = 64'h88776655AA332211; cache_wr_enable high exactly 1 cycle followed by a stable COMMIT cycle.
- Write miss: write 0x5C to 0x0007 with cache_hit = 0.
  - ddram_be = 8'h80; cache_wr_enable never asserted; cpu_ack follows DDRAM acceptance by 1 cycle.
- Busy stall: ddram_busy held high 4 cycles during RD_REQ.
  - ddram_rd and ddram_addr stay constant all 4 cycles; exactly one request is accepted.
- Reset during RD_WAIT: pull reset_n low, release, then pulse ddram_dout_ready in IDLE.
  - No cpu_ack, no cache write, state IDLE, outputs at reset values.
- Back-to-back hits: cpu_req held for 3 requests to different addresses.
  - One cpu_ack every 3 cycles; cpu_rdata matches each line and lane.

Source files
------------

// File: rtl/ddram_cache_ctrl.sv
// Sequencer between the 8-bit CPU bus and the 64-bit DDRAM Avalon port, driving
// a word cache: read-allocate, write-through, no write-allocate.
module ddram_cache_ctrl #(
  parameter int unsigned CPU_ADDR_WIDTH = 16,
  parameter logic [28:0] DDRAM_BASE     = 29'h0600000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]                cpu_wdata,
  output logic [7:0]                cpu_rdata,
  output logic                      cpu_ack,
  output logic [CPU_ADDR_WIDTH-4:0] cache_addr,
  output logic [63:0]               cache_wdata,
  input  logic [63:0]               cache_rdata,
  input  logic                      cache_hit,
  output logic                      cache_wr_enable,
  output logic [28:0]               ddram_addr,
  output logic [7:0]                ddram_burstcnt,
  output logic                      ddram_rd,
  output logic                      ddram_we,
  output logic [63:0]               ddram_din,
  output logic [7:0]                ddram_be,
  input  logic [63:0]               ddram_dout,
  input  logic                      ddram_dout_ready,
  input  logic                      ddram_busy
);

  localparam int unsigned KW = CPU_ADDR_WIDTH - 3;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, FILL, COMMIT, ACK
  } state_t;

  state_t        r_state, w_next;
  logic [KW-1:0] r_cache_addr;
  logic          r_we;
  logic [7:0]    r_wdata;
  logic [2:0]    r_lane;
  logic          r_hit;
  logic [63:0]   r_line;
  logic [63:0]   r_cache_wdata;
  logic [7:0]    r_cpu_rdata;
  logic [63:0]   w_merged;

  always_comb begin
    w_merged = r_line;
    w_merged[{r_lane, 3'b000} +: 8] = r_wdata;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (cpu_req) w_next = LOOKUP;
      LOOKUP:  begin
        if (r_we)           w_next = WR_REQ;
        else if (cache_hit) w_next = ACK;
        else                w_next = RD_REQ;
      end
      RD_REQ:  if (!ddram_busy) w_next = RD_WAIT;
      RD_WAIT: if (ddram_dout_ready) w_next = FILL;
      WR_REQ:  if (!ddram_busy) w_next = r_hit ? FILL : ACK;
      FILL:    w_next = COMMIT;
      COMMIT:  w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cache_addr  <= '0;
      r_we          <= 1'b0;
      r_wdata       <= '0;
      r_lane        <= '0;
      r_hit         <= 1'b0;
      r_line        <= '0;
      r_cache_wdata <= '0;
      r_cpu_rdata   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: if (cpu_req) begin
          r_cache_addr <= cpu_addr[CPU_ADDR_WIDTH-1:3];
          r_we         <= cpu_we;
          r_wdata      <= cpu_wdata;
          r_lane       <= cpu_addr[2:0];
        end
        LOOKUP: begin
          r_hit  <= cache_hit;
          r_line <= cache_rdata;
          if (!r_we && cache_hit) r_cpu_rdata <= cache_rdata[{r_lane, 3'b000} +: 8];
        end
        RD_WAIT: if (ddram_dout_ready) begin
          r_cache_wdata <= ddram_dout;
          r_cpu_rdata   <= ddram_dout[{r_lane, 3'b000} +: 8];
        end
        WR_REQ: if (!ddram_busy && r_hit) r_cache_wdata <= w_merged;
        default: ;
      endcase
    end
  end

  // Strobes decode the registered state, so a reset drops them immediately.
  assign cpu_ack         = (r_state == ACK);
  assign cache_wr_enable = (r_state == FILL);
  assign ddram_rd        = (r_state == RD_REQ);
  assign ddram_we        = (r_state == WR_REQ);

  assign cpu_rdata      = r_cpu_rdata;
  assign cache_addr     = r_cache_addr;
  assign cache_wdata    = r_cache_wdata;
  assign ddram_addr     = DDRAM_BASE + {{(29 - KW){1'b0}}, r_cache_addr};
  assign ddram_burstcnt = 8'd1;
  assign ddram_din      = {8{r_wdata}};
  assign ddram_be       = 8'b1 << r_lane;

endmodule

// File: tb/tb_ddram_cache_ctrl.sv
// Directed bench for ddram_cache_ctrl with a behavioural word cache and a
// DDRAM responder having programmable waitrequest and read latency.
module tb_ddram_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic [12:0] cache_addr;
  logic [63:0] cache_wdata, cache_rdata;
  logic        cache_hit, cache_wr_enable;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt, ddram_be;
  logic        ddram_rd, ddram_we, ddram_dout_ready, ddram_busy;
  logic [63:0] ddram_din, ddram_dout;

  always #5 clk = ~clk;

  ddram_cache_ctrl #(.CPU_ADDR_WIDTH(16), .DDRAM_BASE(29'h0600000)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
    .cache_hit(cache_hit), .cache_wr_enable(cache_wr_enable),
    .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt), .ddram_rd(ddram_rd),
    .ddram_we(ddram_we), .ddram_din(ddram_din), .ddram_be(ddram_be),
    .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready), .ddram_busy(ddram_busy)
  );

  // Cache model: commits on the falling edge of the write strobe unless in reset.
  logic [63:0] cmem [0:8191];
  logic        cval [0:8191];
  assign cache_rdata = cmem[cache_addr];
  assign cache_hit   = cval[cache_addr];

  initial begin
    for (int i = 0; i < 8192; i++) begin
      cmem[i] = '0;
      cval[i] = 1'b0;
    end
    forever begin
      @(negedge cache_wr_enable);
      if (reset_n) begin
        cmem[cache_addr] = cache_wdata;
        cval[cache_addr] = 1'b1;
      end
    end
  end

  // DDRAM responder settings, written only by the main sequence.
  logic [63:0] rd_line = '0;
  int          busy_cfg = 0;
  int          rd_lat = 5;
  int          man_req = 0;

  initial begin
    int  busy_left, lat_left, man_done;
    bit  in_req, pending;
    ddram_busy = 1'b0; ddram_dout_ready = 1'b0; ddram_dout = '0;
    busy_left = 0; lat_left = 0; man_done = 0; in_req = 0; pending = 0;
    forever begin
      @(negedge clk);
      ddram_dout_ready = 1'b0;
      if (!reset_n) begin
        in_req = 0; pending = 0; ddram_busy = 1'b0;
      end else begin
        if (man_req != man_done) begin
          man_done = man_req; ddram_dout_ready = 1'b1; ddram_dout = rd_line;
        end
        if (pending) begin
          lat_left--;
          if (lat_left == 0) begin
            pending = 0; ddram_dout_ready = 1'b1; ddram_dout = rd_line;
          end
        end
        if (ddram_rd || ddram_we) begin
          if (!in_req) begin in_req = 1; busy_left = busy_cfg; end
          if (busy_left > 0) begin
            ddram_busy = 1'b1; busy_left--;
          end else begin
            ddram_busy = 1'b0; in_req = 0;
            if (ddram_rd) begin pending = 1; lat_left = rd_lat; end
          end
        end else begin
          ddram_busy = 1'b0;
        end
      end
    end
  end

  // Bus monitor, sampling shortly before each rising edge.
  int          rd_high = 0, rd_busy = 0, rd_acc = 0, wr_acc = 0, addr_chg = 0;
  int          both_hi = 0, acks = 0, wren_cyc = 0, commit_ok = 0;
  logic [28:0] last_rd_addr = '0, last_wr_addr = '0, prev_addr = '0;
  logic [7:0]  last_be = '0;
  logic [63:0] last_din = '0, prev_cwd = '0;
  logic [12:0] prev_caddr = '0;
  logic        prev_rd = 1'b0, prev_wren = 1'b0;

  always @(negedge clk) begin
    #3;
    if (ddram_rd) rd_high++;
    if (ddram_rd && ddram_busy) rd_busy++;
    if (ddram_rd && !ddram_busy) begin rd_acc++; last_rd_addr = ddram_addr; end
    if (ddram_rd && prev_rd && ddram_addr != prev_addr) addr_chg++;
    if (ddram_we && !ddram_busy) begin
      wr_acc++; last_be = ddram_be; last_din = ddram_din; last_wr_addr = ddram_addr;
    end
    if (ddram_rd && ddram_we) both_hi++;
    if (cpu_ack) acks++;
    if (cache_wr_enable) wren_cyc++;
    if (prev_wren && !cache_wr_enable && cache_addr == prev_caddr && cache_wdata == prev_cwd)
      commit_ok++;
    prev_rd = ddram_rd; prev_addr = ddram_addr;
    prev_wren = cache_wr_enable; prev_caddr = cache_addr; prev_cwd = cache_wdata;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                           output logic [7:0] rd, output int cyc);
    int   n;
    logic got;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (cpu_ack) got = 1'b1;
    end
    check("ack_seen", {63'b0, got}, 64'd1);
    rd = cpu_rdata;
    cyc = n;
  endtask

  task automatic release_req();
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rdat;
    int         cyc, s_acc, s_wacc, s_ack, s_wren, s_cok, s_high, s_busy, s_chg;

    reset_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", {63'b0, cpu_ack}, 64'd0);
    check("rst_wren", {63'b0, cache_wr_enable}, 64'd0);
    check("rst_rd_we", {62'b0, ddram_rd, ddram_we}, 64'd0);
    check("rst_rdata", {56'b0, cpu_rdata}, 64'd0);
    check("rst_caddr", {51'b0, cache_addr}, 64'd0);
    check("rst_cwdata", cache_wdata, 64'd0);
    check("burstcnt", {56'b0, ddram_burstcnt}, 64'd1);
    reset_n = 1'b1;

    // Read miss 0x1234, line returned 5 cycles after acceptance.
    rd_line = 64'h8877665544332211; busy_cfg = 0; rd_lat = 5;
    s_acc = rd_acc; s_wren = wren_cyc; s_cok = commit_ok; s_ack = acks;
    do_access(1'b0, 16'h1234, 8'h00, rdat, cyc);
    release_req();
    check("miss_rdata", {56'b0, rdat}, 64'h55);
    check("miss_cycles", cyc, 10);
    check("miss_cwdata", cache_wdata, 64'h8877665544332211);
    repeat (2) @(negedge clk);
    #4;
    check("miss_rd_pulses", rd_acc - s_acc, 1);
    check("miss_rd_addr", {35'b0, last_rd_addr}, 64'h0600246);
    check("miss_wren", wren_cyc - s_wren, 1);
    check("miss_commit", commit_ok - s_cok, 1);
    check("miss_acks", acks - s_ack, 1);
    check("miss_cache_line", cmem[13'h246], 64'h8877665544332211);
    check("miss_cache_valid", {63'b0, cval[13'h246]}, 64'd1);

    // Repeat read hits without DDRAM traffic.
    s_acc = rd_acc; s_wren = wren_cyc;
    do_access(1'b0, 16'h1234, 8'h00, rdat, cyc);
    release_req();
    check("hit_cycles", cyc, 2);
    check("hit_rdata", {56'b0, rdat}, 64'h55);
    repeat (2) @(negedge clk);
    #4;
    check("hit_no_rd", rd_acc - s_acc, 0);
    check("hit_no_wren", wren_cyc - s_wren, 0);

    // Write hit 0xAA to 0x1233 (lane 3).
    s_wacc = wr_acc; s_wren = wren_cyc; s_cok = commit_ok;
    do_access(1'b1, 16'h1233, 8'hAA, rdat, cyc);
    release_req();
    check("whit_cycles", cyc, 5);
    check("whit_cwdata", cache_wdata, 64'h88776655AA332211);
    repeat (2) @(negedge clk);
    #4;
    check("whit_wr_acc", wr_acc - s_wacc, 1);
    check("whit_be", {56'b0, last_be}, 64'h08);
    check("whit_din", last_din, 64'hAAAA_AAAA_AAAA_AAAA);
    check("whit_wr_addr", {35'b0, last_wr_addr}, 64'h0600246);
    check("whit_wren", wren_cyc - s_wren, 1);
    check("whit_commit", commit_ok - s_cok, 1);
    check("whit_cache_line", cmem[13'h246], 64'h88776655AA332211);

    // Write miss 0x5C to 0x0007 (lane 7).
    s_wacc = wr_acc; s_wren = wren_cyc;
    do_access(1'b1, 16'h0007, 8'h5C, rdat, cyc);
    release_req();
    check("wmiss_cycles", cyc, 3);
    repeat (2) @(negedge clk);
    #4;
    check("wmiss_wr_acc", wr_acc - s_wacc, 1);
    check("wmiss_be", {56'b0, last_be}, 64'h80);
    check("wmiss_din", last_din, 64'h5C5C_5C5C_5C5C_5C5C);
    check("wmiss_wr_addr", {35'b0, last_wr_addr}, 64'h0600000);
    check("wmiss_wren", wren_cyc - s_wren, 0);
    check("wmiss_no_alloc", {63'b0, cval[0]}, 64'd0);

    // Read miss 0x0100 with four busy cycles in RD_REQ.
    rd_line = 64'h0123456789ABCDEF; busy_cfg = 4;
    s_acc = rd_acc; s_high = rd_high; s_busy = rd_busy; s_chg = addr_chg;
    do_access(1'b0, 16'h0100, 8'h00, rdat, cyc);
    release_req();
    busy_cfg = 0;
    check("busy_rdata", {56'b0, rdat}, 64'hEF);
    check("busy_cycles", cyc, 14);
    repeat (2) @(negedge clk);
    #4;
    check("busy_rd_high", rd_high - s_high, 5);
    check("busy_rd_busy", rd_busy - s_busy, 4);
    check("busy_addr_stable", addr_chg - s_chg, 0);
    check("busy_accepts", rd_acc - s_acc, 1);
    check("busy_rd_addr", {35'b0, last_rd_addr}, 64'h0600020);

    // Reset while waiting for read data, then a stale ready pulse in IDLE.
    rd_line = 64'hDEADBEEF_CAFEF00D; rd_lat = 20;
    s_ack = acks; s_wren = wren_cyc;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("rstw_ack", {63'b0, cpu_ack}, 64'd0);
    check("rstw_strobes", {61'b0, ddram_rd, ddram_we, cache_wr_enable}, 64'd0);
    check("rstw_rdata", {56'b0, cpu_rdata}, 64'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    man_req++;
    repeat (4) @(negedge clk);
    #4;
    check("rstw_no_ack", acks - s_ack, 0);
    check("rstw_no_wren", wren_cyc - s_wren, 0);
    check("rstw_no_fill", {63'b0, cval[13'h040]}, 64'd0);
    check("rstw_rdata_after", {56'b0, cpu_rdata}, 64'd0);
    check("rstw_cwdata", cache_wdata, 64'd0);
    check("rstw_caddr", {51'b0, cache_addr}, 64'd0);
    rd_lat = 5;

    // Back in IDLE: a hit completes in the minimum two cycles.
    do_access(1'b0, 16'h1234, 8'h00, rdat, cyc);
    release_req();
    check("post_rst_cycles", cyc, 2);
    check("post_rst_rdata", {56'b0, rdat}, 64'h55);

    // Back-to-back hits with cpu_req held.
    repeat (2) @(negedge clk);
    s_acc = rd_acc;
    do_access(1'b0, 16'h1234, 8'h00, rdat, cyc);
    check("b2b0_cycles", cyc, 2);
    check("b2b0_rdata", {56'b0, rdat}, 64'h55);
    do_access(1'b0, 16'h0101, 8'h00, rdat, cyc);
    check("b2b1_cycles", cyc, 3);
    check("b2b1_rdata", {56'b0, rdat}, 64'hCD);
    do_access(1'b0, 16'h1237, 8'h00, rdat, cyc);
    release_req();
    check("b2b2_cycles", cyc, 3);
    check("b2b2_rdata", {56'b0, rdat}, 64'h88);
    repeat (2) @(negedge clk);
    #4;
    check("b2b_no_rd", rd_acc - s_acc, 0);
    check("rd_we_exclusive", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
